// File: rtl/uart_rx_keymatch.sv
// Oversampling UART receiver with false-start rejection and parity/frame checks.
// Good frames are compared against a key table; each matching key holds its output high for HOLD_CYCLES.
module uart_rx_keymatch #(
    parameter int unsigned               CLK_FREQ    = 100_000_000,
    parameter int unsigned               BAUD_RATE   = 9_600,
    parameter int unsigned               OVERSAMPLE  = 4,
    parameter int unsigned               DATA_BITS   = 8,
    parameter int unsigned               PARITY      = 0,
    parameter int unsigned               STOP_BITS   = 1,
    parameter int unsigned               NUM_KEYS    = 2,
    parameter logic [NUM_KEYS*8-1:0]     KEY_LIST    = {8'h61, 8'h63},
    parameter int unsigned               HOLD_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                RxD,
    output logic [7:0]          RxData,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy,
    output logic [NUM_KEYS-1:0] key_hit
);

    localparam int unsigned     DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned     SW         = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0]   MID        = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]   LAST       = SW'(OVERSAMPLE - 1);
    localparam logic [31:0]     DIV_LAST   = 32'(DIV - 1);
    localparam logic [2:0]      DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic            PAR_TARGET = (PARITY == 1);
    localparam logic [31:0]     HOLD_LOAD  = 32'(HOLD_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rxd_meta_q, rxd_s_q;
    logic [31:0]            div_cnt_q, div_cnt_d;
    logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   pe_acc_q, pe_acc_d;
    logic                   fe_acc_q, fe_acc_d;
    logic                   armed_q, armed_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [31:0]            hold_cnt_q [NUM_KEYS];
    logic [31:0]            hold_cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]    key_hit_q, key_hit_d;
    logic                   tick, mid, bit_end, fe_now;

    assign tick    = (div_cnt_q == DIV_LAST);
    assign mid     = (sample_cnt_q == MID);
    assign bit_end = (sample_cnt_q == LAST);
    assign fe_now  = fe_acc_q | ~rxd_s_q;

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 32'd1;
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pe_acc_d     = pe_acc_q;
        fe_acc_d     = fe_acc_q;
        armed_d      = armed_q | rxd_s_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    // armed drops after a frame ending on a low line, so a break cannot retrigger
                    if (armed_q && !rxd_s_q) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        pe_acc_d     = 1'b0;
                        fe_acc_d     = 1'b0;
                    end
                end
                S_START: begin
                    if (mid && rxd_s_q) begin
                        state_d      = S_IDLE;
                        sample_cnt_d = '0;
                    end else if (bit_end) begin
                        state_d      = S_DATA;
                        sample_cnt_d = '0;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (mid) shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        sample_cnt_d = '0;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (mid) pe_acc_d = ((^shift_q) ^ rxd_s_q) != PAR_TARGET;
                    if (bit_end) begin
                        sample_cnt_d = '0;
                        state_d      = S_STOP;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (mid) fe_acc_d = fe_now;
                    if (mid && bit_cnt_q == STOP_LAST) begin
                        rx_data_d                  = '0;
                        rx_data_d[DATA_BITS-1:0]   = shift_q;
                        parity_err_d               = pe_acc_q;
                        frame_err_d                = fe_now;
                        rx_valid_d                 = 1'b1;
                        state_d                    = S_IDLE;
                        sample_cnt_d               = '0;
                        bit_cnt_d                  = '0;
                        armed_d                    = rxd_s_q;
                    end else if (bit_end) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hold_cnt_d[i] = (hold_cnt_q[i] != '0) ? hold_cnt_q[i] - 32'd1 : '0;
            if (rx_valid_q && !parity_err_q && !frame_err_q &&
                rx_data_q == KEY_LIST[8*i +: 8])
                hold_cnt_d[i] = HOLD_LOAD;
            key_hit_d[i] = (hold_cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q   <= 1'b1;
            rxd_s_q      <= 1'b1;
            div_cnt_q    <= '0;
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pe_acc_q     <= 1'b0;
            fe_acc_q     <= 1'b0;
            armed_q      <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            key_hit_q    <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) hold_cnt_q[i] <= '0;
        end else begin
            rxd_meta_q   <= RxD;
            rxd_s_q      <= rxd_meta_q;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pe_acc_q     <= pe_acc_d;
            fe_acc_q     <= fe_acc_d;
            armed_q      <= armed_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            key_hit_q    <= key_hit_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) hold_cnt_q[i] <= hold_cnt_d[i];
        end
    end

    assign RxData     = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
    assign key_hit    = key_hit_q;

endmodule

// File: tb/tb_uart_rx_keymatch.sv
// Directed bench for uart_rx_keymatch: three instances cover 8N1, even parity and a long hold time.
module tb_uart_rx_keymatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       rxd_a = 1'b1, rxd_p = 1'b1, rxd_h = 1'b1;
    logic [7:0] data_a, data_p, data_h;
    logic       rxv_a, rxv_p, rxv_h;
    logic       pe_a, pe_p, pe_h;
    logic       fe_a, fe_p, fe_h;
    logic       busy_a, busy_p, busy_h;
    logic [1:0] kh_a, kh_p, kh_h;

    uart_rx_keymatch #(.CLK_FREQ(16_000), .BAUD_RATE(1_000), .OVERSAMPLE(4), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .NUM_KEYS(2), .KEY_LIST({8'h61, 8'h63}), .HOLD_CYCLES(100))
    dut_a (.clk(clk), .reset_n(reset_n), .RxD(rxd_a), .RxData(data_a), .rx_valid(rxv_a),
        .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a), .key_hit(kh_a));

    uart_rx_keymatch #(.CLK_FREQ(16_000), .BAUD_RATE(1_000), .OVERSAMPLE(4), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .NUM_KEYS(2), .KEY_LIST({8'h61, 8'h63}), .HOLD_CYCLES(100))
    dut_p (.clk(clk), .reset_n(reset_n), .RxD(rxd_p), .RxData(data_p), .rx_valid(rxv_p),
        .parity_err(pe_p), .frame_err(fe_p), .busy(busy_p), .key_hit(kh_p));

    uart_rx_keymatch #(.CLK_FREQ(16_000), .BAUD_RATE(1_000), .OVERSAMPLE(4), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .NUM_KEYS(2), .KEY_LIST({8'h61, 8'h63}), .HOLD_CYCLES(300))
    dut_h (.clk(clk), .reset_n(reset_n), .RxD(rxd_h), .RxData(data_h), .rx_valid(rxv_h),
        .parity_err(pe_h), .frame_err(fe_h), .busy(busy_h), .key_hit(kh_h));

    int n_total = 0;
    int n_bad   = 0;

    // Negedge monitor; key index 0..3 = a[0], a[1], p[1], h[0]; rx_valid index 0..2 = a, p, h.
    int cyc = 0;
    int run [4]      = '{default: 0};
    int last_len [4] = '{default: 0};
    int rises [4]    = '{default: 0};
    int rise_cyc [4] = '{default: 0};
    int rxv_cnt [3]  = '{default: 0};
    int last_rxv [3] = '{default: 0};
    logic busy_seen = 1'b0;

    always @(negedge clk) begin
        logic [3:0] kv;
        cyc++;
        kv = {kh_h[0], kh_p[1], kh_a[1], kh_a[0]};
        for (int k = 0; k < 4; k++) begin
            if (kv[k]) begin
                if (run[k] == 0) begin
                    rises[k]++;
                    rise_cyc[k] = cyc;
                end
                run[k]++;
            end else if (run[k] != 0) begin
                last_len[k] = run[k];
                run[k]      = 0;
            end
        end
        if (rxv_a) begin rxv_cnt[0]++; last_rxv[0] = cyc; end
        if (rxv_p) begin rxv_cnt[1]++; last_rxv[1] = cyc; end
        if (rxv_h) begin rxv_cnt[2]++; last_rxv[2] = cyc; end
        if (busy_a) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0: rxd_a = v;
            1: rxd_p = v;
            default: rxd_h = v;
        endcase
    endtask

    // b[0] goes on the line first; each bit lasts 16 clocks; line returns idle afterwards.
    task automatic send_bits(input int w, input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(w, b[i]);
            repeat (16) @(posedge clk);
        end
        set_line(w, 1'b1);
    endtask

    int base, base_r, base2;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", data_a, 8'h00);
        check("rst_flags", {rxv_a, pe_a, fe_a, busy_a}, 4'b0000);
        check("rst_key", kh_a, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);

        // 8N1 0x63 -> key 0 for exactly 100 clocks
        base = rxv_cnt[0];
        send_bits(0, {1'b1, 8'h63, 1'b0}, 10);
        repeat (20) @(posedge clk);
        check("t1_rxv_cnt", rxv_cnt[0] - base, 1);
        check("t1_data", data_a, 8'h63);
        check("t1_pe_fe", {pe_a, fe_a}, 2'b00);
        check("t1_key", kh_a, 2'b01);
        check("t1_rise_lat", rise_cyc[0] - last_rxv[0], 1);
        repeat (120) @(posedge clk);
        check("t1_hold_len", last_len[0], 100);
        check("t1_key_off", kh_a, 2'b00);
        check("t1_key1_never", rises[1], 0);

        // even parity: 0x61 has three ones, so correct parity bit is 1
        base = rxv_cnt[1];
        base_r = rises[2];
        send_bits(1, {1'b1, 1'b0, 8'h61, 1'b0}, 11);
        repeat (20) @(posedge clk);
        check("p_bad_rxv", rxv_cnt[1] - base, 1);
        check("p_bad_pe", pe_p, 1'b1);
        check("p_bad_fe", fe_p, 1'b0);
        check("p_bad_data", data_p, 8'h61);
        check("p_bad_key", kh_p, 2'b00);
        check("p_bad_norise", rises[2] - base_r, 0);
        send_bits(1, {1'b1, 1'b1, 8'h61, 1'b0}, 11);
        repeat (20) @(posedge clk);
        check("p_ok_pe", pe_p, 1'b0);
        check("p_ok_key", kh_p, 2'b10);
        repeat (120) @(posedge clk);
        check("p_ok_hold_len", last_len[2], 100);

        // stop bit low then good frame
        send_bits(0, {1'b0, 8'h41, 1'b0}, 10);
        repeat (20) @(posedge clk);
        check("fe_set", fe_a, 1'b1);
        check("fe_data", data_a, 8'h41);
        check("fe_key", kh_a, 2'b00);
        send_bits(0, {1'b1, 8'h63, 1'b0}, 10);
        repeat (20) @(posedge clk);
        check("fe_clear", fe_a, 1'b0);
        check("fe_next_data", data_a, 8'h63);
        check("fe_next_key0", kh_a[0], 1'b1);

        // 5-clock low glitch while idle: false start
        base = rxv_cnt[0];
        busy_seen = 1'b0;
        rxd_a = 1'b0;
        repeat (5) @(posedge clk);
        rxd_a = 1'b1;
        repeat (30) @(posedge clk);
        check("gl_busy_seen", busy_seen, 1'b1);
        check("gl_busy_end", busy_a, 1'b0);
        check("gl_no_rxv", rxv_cnt[0] - base, 0);
        check("gl_data", data_a, 8'h63);
        check("gl_flags", {pe_a, fe_a}, 2'b00);

        // reset in data bit 3 of 0x63 (start, 1, 1, 0, then bit3 = 0)
        send_bits(0, 16'b0110, 4);
        rxd_a = 1'b0;
        repeat (8) @(posedge clk);
        check("rs_busy_before", busy_a, 1'b1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rs_data", data_a, 8'h00);
        check("rs_flags", {rxv_a, pe_a, fe_a, busy_a}, 4'b0000);
        check("rs_key", kh_a, 2'b00);
        rxd_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        send_bits(0, {1'b1, 8'h61, 1'b0}, 10);
        repeat (20) @(posedge clk);
        check("rs_after_data", data_a, 8'h61);
        check("rs_after_flags", {pe_a, fe_a}, 2'b00);
        check("rs_after_key", kh_a, 2'b10);

        // HOLD_CYCLES=300, back-to-back 0x63 frames
        base   = rxv_cnt[2];
        base_r = rises[3];
        send_bits(2, {1'b1, 8'h63, 1'b0}, 10);
        send_bits(2, {1'b1, 8'h63, 1'b0}, 10);
        repeat (20) @(posedge clk);
        check("h_rxv_cnt", rxv_cnt[2] - base, 2);
        check("h_key_mid", kh_h, 2'b01);
        repeat (350) @(posedge clk);
        check("h_one_rise", rises[3] - base_r, 1);
        base2 = rise_cyc[3] + last_len[3] - 1;
        check("h_fall_after_rxv", base2 - last_rxv[2], 300);
        check("h_key_off", kh_h, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_keymatch.md
Name: uart_rx_keymatch

Overview:
Parametrised UART receiver for the vending-machine front end. It supports configurable oversampling, data width, parity and stop bits, and rejects false starts and errors. It matches each received byte against a table of up to 8 key codes (coin/selection keys). A matched key drives a per-key output level high for a programmable hold time.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9_600, line baud rate
OVERSAMPLE, 4, ticks per bit; even, 4..16
DATA_BITS, 8, payload bits per frame, 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
NUM_KEYS, 2, number of key comparators, 1..8
KEY_LIST, {8'h61,8'h63}, packed NUM_KEYS x 8 codes; entry i in bits [8i+7:8i]; compared against zero-extended rx_data
HOLD_CYCLES, 100_000_000, clocks each key_hit stays high after a match

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
RxD  in  1  serial line, idle high, asynchronous to clk
RxData  out  8  last good or errored payload, LSB-first assembled, upper bits zero when DATA_BITS<8
rx_valid  out  1  one-clock pulse at end of each completed frame
parity_err  out  1  parity error of last completed frame; 0 when PARITY=0
frame_err  out  1  any stop bit sampled low in last completed frame
busy  out  1  high from start-bit detect until return to IDLE
key_hit  out  NUM_KEYS  per-key hold level

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, RxData=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, key_hit=0. Synchroniser flops reset to 1.
- RxD passes through a 2-flop synchroniser (rxd_s); 2 clocks of input latency.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor. Counter runs 0..DIV-1 and wraps; tick asserts for one clk at DIV-1. It is free-running and not re-aligned.
- FSM advances only on ticks. sample_cnt counts 0..OVERSAMPLE-1 per bit. MID = OVERSAMPLE/2 - 1.
- IDLE: on tick with rxd_s=0, go to START, sample_cnt=0, busy=1.
- START: at sample_cnt=MID, if rxd_s=1 it is a false start: go to IDLE, no outputs change, busy=0. Otherwise continue to bit end, then enter DATA.
- DATA: sample at MID and shift LSB-first into the shift register. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
- PARITY: sample at MID. Error if XOR(data, pbit) ≠ (PARITY==1 ? 1 : 0).
- STOP: sample each stop bit at MID; any 0 sets a frame error. At MID of the last stop bit, do not wait for the bit end:
  - RxData ← payload; parity_err and frame_err ← frame results; rx_valid=1 for exactly one clk.
  - Go to IDLE; busy=0 the following cycle.
  - Error flags hold until the next completed frame.
- Key match occurs in the rx_valid cycle only when parity_err=0 and frame_err=0. For every i with RxData == KEY_LIST[i], key_hit[i] rises on the next clk and stays high HOLD_CYCLES clocks, using a per-key 32-bit counter.
- A repeat match while key_hit[i] is high restarts that key's counter. Duplicate codes in KEY_LIST raise multiple bits together.
- Errored frames never raise or retrigger key_hit. Frames keep being received while holds are active.
- A line held low (break) gives frame_err=1 and rx_valid pulses. The FSM stays in IDLE until rxd_s=1, then re-arms for the next falling edge.

Test Plan:
Simulation parameters throughout: CLK_FREQ=16_000, BAUD_RATE=1_000, OVERSAMPLE=4 (DIV=4, 16 clk/bit), KEY_LIST={8'h61,8'h63}, HOLD_CYCLES=100.
- 8N1 frame 0x63 → one rx_valid pulse; RxData=0x63; parity_err=0, frame_err=0; key_hit=2'b01 for exactly 100 clk; key_hit[1] never rises.
- PARITY=2, frame 0x61 sent with parity bit 0 (correct value is 1) → rx_valid with parity_err=1, RxData=0x61, key_hit stays 0. Resend with parity bit 1 → parity_err=0, key_hit[1] high for 100 clk.
- Frame 0x41 with stop bit 0 → frame_err=1. Following good 0x63 → frame_err=0, RxData=0x63, key_hit[0]=1.
- RxD low glitch of 5 clk while idle → busy pulses, then returns 0. No rx_valid; outputs unchanged.
- reset_n low during data bit 3 of a frame → all outputs 0 within the same cycle. After release and line idle, the next 0x61 decodes correctly.
- HOLD_CYCLES=300, two back-to-back 0x63 frames → key_hit[0] stays continuously high and falls 300 clk after the second rx_valid.
